vga_fb_arbiter: RTL

- Shares one single-port synchronous framebuffer RAM between the VGA scan-out path and a draw engine.
- Display fetch has guaranteed bandwidth: the block prefetches pixels sequentially into a small pixel FIFO read by the timing generator.
- Draw reads and writes get every slot the display does not urgently need.
- Sits between the VGA timing generator and the framebuffer RAM.

---
 rtl/vga_pkg.sv | 9 +
 rtl/vga_pix_fifo.sv | 60 ++++++
 rtl/vga_fb_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared framebuffer geometry and arbiter types for the VGA framebuffer path.
package vga_pkg;
  localparam int unsigned H_ACTIVE  = 640;
  localparam int unsigned V_ACTIVE  = 480;
  localparam int unsigned FB_PIXELS = H_ACTIVE * V_ACTIVE;

  typedef enum logic [1:0] {IDLE, FETCH, DONE} arb_state_t;
  typedef enum logic {OWN_DISP, OWN_DRW} owner_t;
endpackage

// File: rtl/vga_pix_fifo.sv
// Small synchronous pixel FIFO between framebuffer fetch and the timing generator.
// The head output holds its last shown value while the FIFO is empty.
module vga_pix_fifo #(
  parameter int unsigned DATA_W = 3,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] hold_q;
  logic              do_push;
  logic              do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = cnt_q;
  assign rdata   = empty ? hold_q : mem[rd_ptr];

  // Pointers, occupancy and the held head value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      hold_q <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      hold_q <= rdata;
    end else begin
      hold_q <= rdata;
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: entries are only read once counted in
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares a single-port framebuffer RAM between sequential display prefetch
// and a draw engine; display wins whenever its FIFO is close to running dry.
module vga_fb_arbiter #(
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DATA_W     = 3,
  parameter int unsigned H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LOW_WM     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              pix_rd,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              underrun,
  input  logic              drw_req,
  input  logic              drw_we,
  input  logic [ADDR_W-1:0] drw_addr,
  input  logic [DATA_W-1:0] drw_wdata,
  output logic              drw_gnt,
  output logic [DATA_W-1:0] drw_rdata,
  output logic              drw_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import vga_pkg::*;

  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned FRAME_PIX = H_ACTIVE * V_ACTIVE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);

  arb_state_t        state_q;
  arb_state_t        state_d;
  logic [ADDR_W-1:0] fetch_addr;
  logic              rd_pend;
  owner_t            rd_owner;
  logic [DATA_W-1:0] drw_rdata_q;
  logic              disp_issue;
  logic              disp_pend;
  logic              fifo_push;
  logic              fifo_pop;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  occ;
  logic              fifo_empty;
  logic              fifo_full;

  // occ counts the in-flight display read so a push can never overflow
  assign disp_pend = rd_pend && (rd_owner == OWN_DISP);
  assign occ       = fifo_count + CNT_W'(disp_pend);
  assign fifo_push = disp_pend && !frame_start;
  assign fifo_pop  = pix_rd && !fifo_empty && !frame_start;
  assign pix_valid = !fifo_empty;
  assign drw_rdata = drw_rvalid ? mem_rdata : drw_rdata_q;

  vga_pix_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (frame_start),
    .push  (fifo_push),
    .wdata (mem_rdata),
    .pop   (fifo_pop),
    .rdata (pix_data),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: frame_start restarts from any state
  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = FETCH;
    end else if (state_q == FETCH && disp_issue && fetch_addr == LAST_ADDR) begin
      state_d = DONE;
    end
  end

  // Slot arbitration and RAM port drive; a frame_start cycle issues no display read
  always_comb begin
    disp_issue = 1'b0;
    drw_gnt    = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (reset) begin
      if (state_q != FETCH) begin
        drw_gnt = drw_req;
      end else if (occ <= CNT_W'(LOW_WM)) begin
        disp_issue = !frame_start;
      end else if (drw_req) begin
        drw_gnt = 1'b1;
      end else if (!fifo_full && occ < CNT_W'(FIFO_DEPTH)) begin
        disp_issue = !frame_start;
      end

      if (drw_gnt) begin
        mem_en    = 1'b1;
        mem_we    = drw_we;
        mem_addr  = drw_addr;
        mem_wdata = drw_wdata;
      end else if (disp_issue) begin
        mem_en   = 1'b1;
        mem_addr = fetch_addr;
      end
    end
  end

  // Read tracking, fetch pointer and sticky underrun
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_addr  <= '0;
      rd_pend     <= 1'b0;
      rd_owner    <= OWN_DISP;
      underrun    <= 1'b0;
      drw_rvalid  <= 1'b0;
      drw_rdata_q <= '0;
    end else begin
      rd_pend     <= mem_en && !mem_we;
      rd_owner    <= drw_gnt ? OWN_DRW : OWN_DISP;
      drw_rvalid  <= drw_gnt && !drw_we;
      drw_rdata_q <= drw_rdata;
      if (frame_start) begin
        fetch_addr <= '0;
        underrun   <= 1'b0;
      end else begin
        if (disp_issue)            fetch_addr <= fetch_addr + ADDR_W'(1);
        if (pix_rd && fifo_empty)  underrun   <= 1'b1;
      end
    end
  end
endmodule
